// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: PLL lock/reset-request inputs and core reset/status outputs of the sequencer
interface pll_reset_sequencer_if #(
   parameter int CNT_WIDTH = 8
);
   logic pllLocked;
   logic extReset;
   logic coreReset;
   logic ready;
   logic tick;
   logic lockLost;
   logic [CNT_WIDTH-1:0] lossCount;
   modport master (output pllLocked, extReset, input coreReset, ready, tick, lockLost, lossCount);
   modport slave (input pllLocked, extReset, output coreReset, ready, tick, lockLost, lossCount);
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock, holds then releases core reset, supervises lock and ticks.
// Define PLL_RESET_LOSS_COUNT_EN to implement the saturating lossCount counter (tied to 0 otherwise).
module pll_reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_WAIT = 1024,
   parameter int RESET_HOLD = 16,
   parameter int TICK_DIV = 42,
   parameter int CNT_WIDTH = 8
) (
   input logic clk,
   input logic resetN,
   pll_reset_sequencer_if.slave bus
);
   localparam int LW = LOCK_WAIT > 1 ? $clog2(LOCK_WAIT) : 1;
   localparam int HW = RESET_HOLD > 1 ? $clog2(RESET_HOLD) : 1;
   localparam int PW = LW > HW ? LW : HW;
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LOCK_LAST = PW'(LOCK_WAIT - 1);
   localparam logic [PW-1:0] HOLD_LAST = PW'(RESET_HOLD - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] lockPipe;
   logic [SYNC_STAGES-1:0] extPipe;
   logic lockSync;
   logic extSync;
   logic [PW-1:0] phaseCnt;
   logic [TW-1:0] tickCnt;
   logic [TW-1:0] tickNext;
   logic coreReset;
   logic ready;
   logic tick;
   logic lockLost;
   assign lockSync = lockPipe[SYNC_STAGES-1];
   assign extSync = extPipe[SYNC_STAGES-1];
   assign tickNext = tickCnt == TICK_LAST ? '0 : tickCnt + 1'b1;
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         lockPipe <= '0;
         extPipe <= '0;
      end else begin
         lockPipe <= {lockPipe[SYNC_STAGES-2:0], bus.pllLocked};
         extPipe <= {extPipe[SYNC_STAGES-2:0], bus.extReset};
      end
   // Lock loss outranks every other condition, so it is decided before the per-state logic.
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         state <= WAIT_LOCK;
         phaseCnt <= '0;
         tickCnt <= '0;
         coreReset <= 1'b1;
         ready <= 1'b0;
         tick <= 1'b0;
         lockLost <= 1'b0;
      end else begin
         lockLost <= 1'b0;
         tick <= 1'b0;
         tickCnt <= '0;
         if (!lockSync) begin
            state <= WAIT_LOCK;
            phaseCnt <= '0;
            coreReset <= 1'b1;
            ready <= 1'b0;
            lockLost <= state == RUN;
         end else
            case (state)
               WAIT_LOCK: begin
                  state <= STABLE;
                  phaseCnt <= '0;
               end
               STABLE:
                  if (extSync) phaseCnt <= '0;
                  else if (phaseCnt == LOCK_LAST) begin
                     state <= HOLD;
                     phaseCnt <= '0;
                  end else phaseCnt <= phaseCnt + 1'b1;
               HOLD:
                  if (extSync) phaseCnt <= '0;
                  else if (phaseCnt == HOLD_LAST) begin
                     state <= RUN;
                     phaseCnt <= '0;
                     coreReset <= 1'b0;
                     ready <= 1'b1;
                  end else phaseCnt <= phaseCnt + 1'b1;
               RUN:
                  if (extSync) begin
                     state <= HOLD;
                     phaseCnt <= '0;
                     coreReset <= 1'b1;
                     ready <= 1'b0;
                  end else begin
                     tickCnt <= tickNext;
                     tick <= tickNext == TICK_LAST;
                  end
            endcase
      end
`ifdef PLL_RESET_LOSS_COUNT_EN
   logic [CNT_WIDTH-1:0] lossCount;
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) lossCount <= '0;
      else if (state == RUN && !lockSync && lossCount != '1) lossCount <= lossCount + 1'b1;
   assign bus.lossCount = lossCount;
`else
   assign bus.lossCount = {CNT_WIDTH{1'b0}};
`endif
   assign bus.coreReset = coreReset;
   assign bus.ready = ready;
   assign bus.tick = tick;
   assign bus.lockLost = lockLost;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard bench; expected outputs are queued per clock edge from the timing rules.
module tb_pll_reset_sequencer;
   localparam int SYNC_STAGES = 2;
   localparam int LOCK_WAIT = 8;
   localparam int RESET_HOLD = 4;
   localparam int TICK_DIV = 5;
   localparam int CNT_WIDTH = 2;
   localparam int QUAL = SYNC_STAGES + LOCK_WAIT + RESET_HOLD;
   localparam int NEVER = 1 << 30;
   typedef struct {
      int at;
      string tag;
      logic [5:0] v;
   } exp_t;
   logic clk = 1'b0;
   logic resetN = 1'b0;
   int edges = 0;
   int vectors = 0;
   int miscompares = 0;
   int lossExp = 0;
   int runStart = 0;
   exp_t sb[$];
   exp_t head;
   pll_reset_sequencer_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();
   pll_reset_sequencer #(
      .SYNC_STAGES(SYNC_STAGES),
      .LOCK_WAIT(LOCK_WAIT),
      .RESET_HOLD(RESET_HOLD),
      .TICK_DIV(TICK_DIV),
      .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;
   function automatic logic [5:0] outs();
      return {bus.coreReset, bus.ready, bus.tick, bus.lockLost, bus.lossCount};
   endfunction
   task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s @edge %0d: got %b want %b ({coreReset,ready,tick,lockLost,lossCount})", tag, edges, got, want);
      end
   endtask
   always @(negedge clk)
      while (sb.size() > 0 && sb[0].at == edges) begin
         head = sb.pop_front();
         check(head.tag, outs(), head.v);
      end
   function automatic int bump(input int x);
`ifdef PLL_RESET_LOSS_COUNT_EN
      return x < (1 << CNT_WIDTH) - 1 ? x + 1 : x;
`else
      return 0 * x;
`endif
   endfunction
   task automatic step();
      @(negedge clk);
      #1;
   endtask
   task automatic wait_to(input int e);
      while (edges < e - 1) step();
   endtask
   task automatic span(input int from, input int to, input int runFrom, input int runTo, input int lostAt,
                       input int lcPre, input int lcPost, input string tag);
      for (int e = from; e <= to; e++) begin
         bit run = e >= runFrom && e < runTo;
         bit tk = run && (e - runFrom) % TICK_DIV == TICK_DIV - 1;
         int lc = e >= lostAt ? lcPost : lcPre;
         sb.push_back('{at: e, tag: tag, v: {~run, run, tk, e == lostAt, 2'(lc)}});
      end
   endtask
   task automatic drain();
      for (int i = 0; i < 400 && sb.size() > 0; i++) @(posedge clk);
      check("drain", {5'b0, sb.size() != 0}, 6'b0);
      sb.delete();
      step();
   endtask
   task automatic relock(input string tag);
      int m;
      bus.pllLocked = 1'b1;
      m = edges + 1;
      runStart = m + QUAL;
      span(m, runStart + 6, runStart, NEVER, NEVER, lossExp, lossExp, tag);
      drain();
   endtask
   initial begin
      int e, g, h, nl;
      bus.pllLocked = 1'b0;
      bus.extReset = 1'b0;
      repeat (3) step();
      check("reset", outs(), 6'b100000);
      resetN = 1'b1;
      step();
      bus.pllLocked = 1'b1;
      e = edges + 1;
      runStart = e + QUAL;
      span(e, runStart + 12, runStart, NEVER, NEVER, 0, 0, "powerup");
      drain();
      bus.extReset = 1'b1;
      e = edges + 1;
      span(e, e + 1, runStart, NEVER, NEVER, lossExp, lossExp, "ext-pre");
      runStart = e + 2 + RESET_HOLD;
      span(e + 2, runStart + 11, runStart, NEVER, NEVER, lossExp, lossExp, "ext");
      step();
      bus.extReset = 1'b0;
      drain();
      for (int n = 0; n < 5; n++) begin
         repeat (n) step();
         bus.pllLocked = 1'b0;
         e = edges + 1;
         nl = bump(lossExp);
         span(e, e + 5, runStart, e + 2, e + 2, lossExp, nl, "loss");
         lossExp = nl;
         drain();
         relock("relock");
      end
      bus.pllLocked = 1'b0;
      bus.extReset = 1'b1;
      e = edges + 1;
      nl = bump(lossExp);
      span(e, e + 8, runStart, e + 2, e + 2, lossExp, nl, "both");
      lossExp = nl;
      step();
      bus.extReset = 1'b0;
      drain();
      relock("both-relock");
      repeat (3) step();
      check("pre-async", {5'b0, bus.ready}, 6'd1);
      #2 resetN = 1'b0;
      #1 check("async", outs(), 6'b100000);
      bus.pllLocked = 1'b0;
      repeat (2) step();
      resetN = 1'b1;
      lossExp = 0;
      step();
      bus.pllLocked = 1'b1;
      e = edges + 1;
      g = e + SYNC_STAGES + 6;
      h = g + 3;
      runStart = h + QUAL;
      span(e, runStart + 6, runStart, NEVER, NEVER, 0, 0, "glitch");
      wait_to(g);
      bus.pllLocked = 1'b0;
      wait_to(h);
      bus.pllLocked = 1'b1;
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end
endmodule
